rob: RTL and testbench
======================

# rob

Reorder buffer on the responder side of the rename-to-ROB allocation interface. It supplies the next two ROB tags and a free-slot indication to rename, and accepts up to two new entries per cycle. It marks entries complete from two writeback ports and retires up to two ready entries per cycle in program order through the two commit write ports that feed the PRF. A ready head entry carrying an exception raises a one-cycle flush request instead of retiring.

## Interface
- ROB_DEPTH, 32: number of entries; power of two, ≥4; TAG_WIDTH = log2(ROB_DEPTH).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  external pipeline flush; clears the buffer synchronously
- rob_rdy  out  2  free slots: 00 = 0, 01 = 1, 10 = 2 or more (11 never driven)
- rob_tag0 / rob_tag1  out  TAG_WIDTH each  tail and tail+1 (mod ROB_DEPTH)
- rob_entry0 / rob_entry1  in  rob_entry_t each  entries written at rob_tag0 / rob_tag1
- rob_we  in  2  bit0 writes entry0, bit1 writes entry1
- wb0_val / wb1_val  in  1 each  writeback valid
- wb0_tag / wb1_tag  in  TAG_WIDTH each  completing entry
- wb0_result / wb1_result  in  32 each  result data
- wb0_exc / wb1_exc  in  1 each  exception flag
- commit_0_write_port / commit_1_write_port  out  commit_write_port_t each  fields we, addr (rd), tag (slot index), data (result)
- exc_flush  out  1  exception flush request
- exc_pc  out  32  pc of the excepting entry

## Operation
- State: head and tail pointers (TAG_WIDTH), count (TAG_WIDTH+1), per-slot rob_entry_t array.
- Allocation: if rob_we[0], slot tail ← rob_entry0 with is_valid=1, is_ready=0, has_exception=0. If rob_we[1], slot tail+1 ← rob_entry1, same initialisation.
- Tail and count advance by 2 when rob_we[1]=1, and by 1 when rob_we==01.
- rob_we==10: slot tail becomes a bubble with is_valid=1, is_ready=1, has_rd=0. It retires without a PRF write.
- Writeback: wbN_val sets is_ready=1, writes result, and ORs wbN_exc into has_exception of slot wbN_tag. Both ports may hit different slots in the same cycle. The same slot on both ports is illegal (assertion).
- Commit slot 0 fires when head is valid, ready and not excepting. Slot 1 fires when slot 0 fires and head+1 is valid, ready and not excepting.
- Committed slots get is_valid cleared. Head advances by the number committed, and count decreases by the same.
- commit_N_write_port.we = fire && has_rd && rd≠0; addr=rd, tag=slot index, data=result.
- Exception: head is valid, ready and has_exception. There is no commit that cycle; exc_flush=1 and exc_pc=head pc. The next edge clears every slot's is_valid and sets head=tail=count=0.
- An exception at head+1 when head commits: head retires normally; head+1 raises on the following cycle.
- flush=1: same clear as exception on the next edge. It overrides allocation, writeback and commit in that cycle.
- rob_we while rob_rdy is insufficient (01 with two entries, 00 with any) is illegal. An assertion fires and the write is ignored.

## Timing
- rob_rdy, rob_tag0/1 and the commit ports are combinational from registered state only (head, tail, count, array). There are no paths from rob_we or wb inputs.
- rob_rdy reflects start-of-cycle count; same-cycle commits do not free slots for allocation until the next cycle.
- Writeback at edge N makes the entry eligible to commit in cycle N+1. Allocation to commit takes at least 2 cycles.
- Pointers wrap modulo ROB_DEPTH. Full means count==ROB_DEPTH; empty means count==0.
- Reset values (async assert, synchronous release):
  - head=tail=count=0; all is_valid=0
  - rob_rdy=10; rob_tag0=0, rob_tag1=1
  - both commit port we=0; exc_flush=0; exc_pc=0
- Reset asserted mid-operation discards all entries immediately.

## Test plan
- Reset, allocate two entries (rd=5, rd=6), writeback both with results 0xA and 0xB, one cycle later -> commit_0 we=1 addr=5 tag=0 data=0xA; commit_1 we=1 addr=6 tag=1 data=0xB; count returns to 0.
- Allocate 32 entries (ROB_DEPTH=32) -> rob_rdy 10 through count=30, 01 at 31, 00 at 32. Commit one -> rob_rdy=01 the following cycle.
- Out-of-order writeback: tags 0,1,2 allocated; writeback 2, then 1, then 0 -> no commit until tag 0 is ready, then tags 0 and 1 retire together, then tag 2 next cycle.
- rob_we=10 with tail=4 -> slot 4 is a bubble and tail=6. When it reaches head it retires with commit we=0.
- Writeback tag 3 with exc=1 at head=3, pc=0x100 -> exc_flush=1 and exc_pc=0x100 for one cycle, no commit. The next cycle shows count=0, tags 0/1.
- Wrap: run head/tail past 31 to 0 with continuous 2-wide allocate and commit for 100 cycles -> commit tags in strict sequence mod 32, with no lost or duplicated entry.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: two-wide allocation from rename, two writeback ports, two-wide
// in-order retirement to the PRF, and a one-cycle flush request on an excepting head.
package rob_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int TAG_WIDTH = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic        is_valid;
    logic        is_ready;
    logic        has_exception;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] result;
  } rob_entry_t;

  typedef struct packed {
    logic                 we;
    logic [4:0]           addr;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } commit_write_port_t;
endpackage

module rob #(
  parameter int  ROB_DEPTH = rob_pkg::ROB_DEPTH,
  localparam int TAG_WIDTH = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  output logic [1:0]                  rob_rdy,
  output logic [TAG_WIDTH-1:0]        rob_tag0,
  output logic [TAG_WIDTH-1:0]        rob_tag1,
  input  rob_pkg::rob_entry_t         rob_entry0,
  input  rob_pkg::rob_entry_t         rob_entry1,
  input  logic [1:0]                  rob_we,
  input  logic                        wb0_val,
  input  logic [TAG_WIDTH-1:0]        wb0_tag,
  input  logic [31:0]                 wb0_result,
  input  logic                        wb0_exc,
  input  logic                        wb1_val,
  input  logic [TAG_WIDTH-1:0]        wb1_tag,
  input  logic [31:0]                 wb1_result,
  input  logic                        wb1_exc,
  output rob_pkg::commit_write_port_t commit_0_write_port,
  output rob_pkg::commit_write_port_t commit_1_write_port,
  output logic                        exc_flush,
  output logic [31:0]                 exc_pc
);
  localparam int CW  = TAG_WIDTH + 1;
  localparam int PTW = rob_pkg::TAG_WIDTH;

  rob_pkg::rob_entry_t  entries [ROB_DEPTH];
  logic [TAG_WIDTH-1:0] head, tail, head1, tail1;
  logic [CW-1:0]        count, free;
  logic [1:0]           alloc_req, alloc_n, commit_n;
  logic                 alloc_ok, fire0, fire1, exc_now, clear;
  rob_pkg::rob_entry_t  e0, new0, new1;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    head1    = head + TAG_WIDTH'(1);
    tail1    = tail + TAG_WIDTH'(1);
    e0       = entries[head];
    exc_now  = e0.is_valid && e0.is_ready && e0.has_exception;
    fire0    = e0.is_valid && e0.is_ready && !e0.has_exception;
    fire1    = fire0 && entries[head1].is_valid && entries[head1].is_ready
               && !entries[head1].has_exception;
    commit_n = {1'b0, fire0} + {1'b0, fire1};
    clear    = flush || exc_now;

    // Readiness uses start-of-cycle occupancy; slots freed by this cycle's commit count next cycle.
    free      = CW'(ROB_DEPTH) - count;
    rob_rdy   = (count <= CW'(ROB_DEPTH - 2)) ? 2'b10 :
                (count == CW'(ROB_DEPTH - 1)) ? 2'b01 : 2'b00;
    alloc_req = rob_we[1] ? 2'd2 : {1'b0, rob_we[0]};
    alloc_ok  = CW'(alloc_req) <= free;
    alloc_n   = alloc_ok ? alloc_req : 2'd0;

    // rob_we == 10 turns slot tail into a pre-completed bubble with no destination.
    new0               = rob_entry0;
    new0.is_valid      = 1'b1;
    new0.is_ready      = (rob_we == 2'b10);
    new0.has_exception = 1'b0;
    if (rob_we == 2'b10) new0.has_rd = 1'b0;
    new1               = rob_entry1;
    new1.is_valid      = 1'b1;
    new1.is_ready      = 1'b0;
    new1.has_exception = 1'b0;
  end

  always_comb begin
    rob_tag0 = tail;
    rob_tag1 = tail1;

    commit_0_write_port.we   = fire0 && e0.has_rd && (e0.rd != 5'd0);
    commit_0_write_port.addr = e0.rd;
    commit_0_write_port.tag  = PTW'(head);
    commit_0_write_port.data = e0.result;

    commit_1_write_port.we   = fire1 && entries[head1].has_rd && (entries[head1].rd != 5'd0);
    commit_1_write_port.addr = entries[head1].rd;
    commit_1_write_port.tag  = PTW'(head1);
    commit_1_write_port.data = entries[head1].result;

    exc_flush = exc_now;
    exc_pc    = exc_now ? e0.pc : 32'h0;
  end

  // NOTE: state updates use non-blocking assignments so later writes in this block win cleanly per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: the whole array is reset so commit ports never expose X after reset.
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) entries[i].is_valid <= 1'b0;
    end else begin
      if (wb0_val) begin
        entries[wb0_tag].is_ready      <= 1'b1;
        entries[wb0_tag].result        <= wb0_result;
        entries[wb0_tag].has_exception <= entries[wb0_tag].has_exception | wb0_exc;
      end
      if (wb1_val) begin
        entries[wb1_tag].is_ready      <= 1'b1;
        entries[wb1_tag].result        <= wb1_result;
        entries[wb1_tag].has_exception <= entries[wb1_tag].has_exception | wb1_exc;
      end
      if (alloc_n != 2'd0) entries[tail]  <= new0;
      if (alloc_n == 2'd2) entries[tail1] <= new1;
      if (fire0) entries[head].is_valid  <= 1'b0;
      if (fire1) entries[head1].is_valid <= 1'b0;
      head  <= head + TAG_WIDTH'(commit_n);
      tail  <= tail + TAG_WIDTH'(alloc_n);
      count <= count + CW'(alloc_n) - CW'(commit_n);
    end
  end

  a_wb_distinct: assert property (@(posedge clk) disable iff (!rst || flush)
    !(wb0_val && wb1_val && (wb0_tag == wb1_tag)));
  a_alloc_room: assert property (@(posedge clk) disable iff (!rst || flush)
    (rob_we == 2'b00) || alloc_ok);
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus randomized traffic, all checked every cycle
// against a queue-based program-order model of the buffer.
module tb_rob;
  import rob_pkg::*;
  localparam int D = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic [1:0]         rob_rdy;
  logic [4:0]         rob_tag0, rob_tag1;
  rob_entry_t         rob_entry0 = '0, rob_entry1 = '0;
  logic [1:0]         rob_we = 2'b00;
  logic               wb0_val = 1'b0, wb1_val = 1'b0, wb0_exc = 1'b0, wb1_exc = 1'b0;
  logic [4:0]         wb0_tag = '0, wb1_tag = '0;
  logic [31:0]        wb0_result = '0, wb1_result = '0;
  commit_write_port_t commit_0_write_port, commit_1_write_port;
  logic               exc_flush;
  logic [31:0]        exc_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int        tag;
    bit        ready;
    bit        exc;
    bit        has_rd;
    bit [4:0]  rd;
    bit [31:0] pc;
    bit [31:0] result;
  } ment_t;
  ment_t q[$];
  int    tail_m = 0;

  rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rob_rdy(rob_rdy), .rob_tag0(rob_tag0), .rob_tag1(rob_tag1),
    .rob_entry0(rob_entry0), .rob_entry1(rob_entry1), .rob_we(rob_we),
    .wb0_val(wb0_val), .wb0_tag(wb0_tag), .wb0_result(wb0_result), .wb0_exc(wb0_exc),
    .wb1_val(wb1_val), .wb1_tag(wb1_tag), .wb1_result(wb1_result), .wb1_exc(wb1_exc),
    .commit_0_write_port(commit_0_write_port), .commit_1_write_port(commit_1_write_port),
    .exc_flush(exc_flush), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Control bits are filled with junk: the buffer must ignore them on allocation.
  function automatic rob_entry_t mk(input bit has_rd, input logic [4:0] rd, input logic [31:0] pc);
    rob_entry_t e;
    e               = '0;
    e.is_valid      = 1'b0;
    e.is_ready      = 1'b1;
    e.has_exception = 1'b1;
    e.has_rd        = has_rd;
    e.rd            = rd;
    e.pc            = pc;
    e.result        = $urandom;
    return e;
  endfunction

  task automatic idle();
    rob_we = 2'b00; flush = 1'b0;
    wb0_val = 1'b0; wb1_val = 1'b0; wb0_exc = 1'b0; wb1_exc = 1'b0;
  endtask

  task automatic wb_apply(input logic [4:0] t, input logic [31:0] r, input bit x);
    foreach (q[i]) if (q[i].tag == int'(t)) begin
      q[i].ready  = 1'b1;
      q[i].result = r;
      q[i].exc    = q[i].exc | x;
    end
  endtask

  task automatic check_port(input string p, input commit_write_port_t c, input bit fire, input ment_t m);
    bit we;
    we = fire && m.has_rd && (m.rd != 5'd0);
    check({p, "_we"}, c.we, we);
    if (we) begin
      check({p, "_addr"}, c.addr, m.rd);
      check({p, "_tag"}, c.tag, m.tag);
      check({p, "_data"}, c.data, m.result);
    end
  endtask

  // Called at a falling edge with inputs already set: check outputs, clock once, update model.
  task automatic tick();
    int       free;
    bit       ef, f0, f1;
    ment_t    m, h0, h1;
    logic [1:0] er;
    free = D - q.size();
    er   = (free >= 2) ? 2'b10 : 2'(free);
    check("rob_rdy", rob_rdy, er);
    check("rob_tag0", rob_tag0, tail_m);
    check("rob_tag1", rob_tag1, (tail_m + 1) % D);
    ef = 0; f0 = 0; f1 = 0;
    h0 = '{default: 0};
    h1 = '{default: 0};
    if (q.size() > 0) h0 = q[0];
    if (q.size() > 1) h1 = q[1];
    if (q.size() > 0 && h0.ready) begin
      if (h0.exc) ef = 1; else f0 = 1;
    end
    if (f0 && q.size() > 1 && h1.ready && !h1.exc) f1 = 1;
    check("exc_flush", exc_flush, ef);
    check("exc_pc", exc_pc, ef ? h0.pc : 32'h0);
    check_port("c0", commit_0_write_port, f0, h0);
    check_port("c1", commit_1_write_port, f1, h1);
    @(posedge clk);
    if (flush || ef) begin
      q.delete();
      tail_m = 0;
    end else begin
      if (wb0_val) wb_apply(wb0_tag, wb0_result, wb0_exc);
      if (wb1_val) wb_apply(wb1_tag, wb1_result, wb1_exc);
      if (f0) void'(q.pop_front());
      if (f1) void'(q.pop_front());
      if (rob_we != 2'b00) begin
        m = '{tag: tail_m, ready: 0, exc: 0, has_rd: rob_entry0.has_rd,
              rd: rob_entry0.rd, pc: rob_entry0.pc, result: 0};
        if (rob_we == 2'b10) begin m.ready = 1; m.has_rd = 0; end
        q.push_back(m);
        if (rob_we[1]) begin
          m = '{tag: (tail_m + 1) % D, ready: 0, exc: 0, has_rd: rob_entry1.has_rd,
                rd: rob_entry1.rd, pc: rob_entry1.pc, result: 0};
          q.push_back(m);
        end
        tail_m = (tail_m + (rob_we[1] ? 2 : 1)) % D;
      end
    end
    @(negedge clk);
    idle();
  endtask

  // Writebacks to distinct not-yet-complete entries, either oldest-first or random.
  task automatic pick_wb(input bit oldest, input int exc_pct);
    int idx[$];
    int k;
    foreach (q[i]) if (!q[i].ready) idx.push_back(i);
    if (idx.size() > 0 && (oldest || $urandom_range(0, 1) == 1)) begin
      k = oldest ? 0 : int'($urandom_range(0, idx.size() - 1));
      wb0_val = 1; wb0_tag = 5'(q[idx[k]].tag); wb0_result = $urandom;
      wb0_exc = ($urandom_range(0, 99) < exc_pct);
      idx.delete(k);
    end
    if (idx.size() > 0 && (oldest || $urandom_range(0, 1) == 1)) begin
      k = oldest ? 0 : int'($urandom_range(0, idx.size() - 1));
      wb1_val = 1; wb1_tag = 5'(q[idx[k]].tag); wb1_result = $urandom;
      wb1_exc = ($urandom_range(0, 99) < exc_pct);
    end
  endtask

  task automatic rand_cycle(input int exc_pct, input int flush_pct);
    int free;
    logic [1:0] r;
    free = D - q.size();
    r = 2'($urandom_range(0, 3));
    if (free < 2 && r[1]) r = (free == 1) ? 2'b01 : 2'b00;
    if (free == 0) r = 2'b00;
    rob_we = r;
    rob_entry0 = mk(1'($urandom), 5'($urandom), $urandom);
    rob_entry1 = mk(1'($urandom), 5'($urandom), $urandom);
    pick_wb(1'b0, exc_pct);
    flush = ($urandom_range(0, 99) < flush_pct);
    tick();
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    check("reset_rdy", rob_rdy, 2'b10);
    check("reset_tag0", rob_tag0, 0);
    check("reset_tag1", rob_tag1, 1);
    check("reset_c0_we", commit_0_write_port.we, 0);
    check("reset_c1_we", commit_1_write_port.we, 0);
    check("reset_exc_flush", exc_flush, 0);
    check("reset_exc_pc", exc_pc, 0);
    rst = 1'b1;
    tick();

    // Two entries, both written back, retire together.
    rob_we = 2'b11; rob_entry0 = mk(1, 5, 32'h0); rob_entry1 = mk(1, 6, 32'h4); tick();
    wb0_val = 1; wb0_tag = 0; wb0_result = 32'hA;
    wb1_val = 1; wb1_tag = 1; wb1_result = 32'hB; tick();
    check("t1_c0_we", commit_0_write_port.we, 1);
    check("t1_c0_addr", commit_0_write_port.addr, 5);
    check("t1_c0_tag", commit_0_write_port.tag, 0);
    check("t1_c0_data", commit_0_write_port.data, 32'hA);
    check("t1_c1_we", commit_1_write_port.we, 1);
    check("t1_c1_addr", commit_1_write_port.addr, 6);
    check("t1_c1_tag", commit_1_write_port.tag, 1);
    check("t1_c1_data", commit_1_write_port.data, 32'hB);
    tick();
    check("t1_rdy_empty", rob_rdy, 2'b10);
    check("t1_tag0", rob_tag0, 2);

    // Fill one at a time to full; one retirement frees a slot the cycle after.
    flush = 1; tick();
    for (int i = 0; i < D; i++) begin
      rob_we = 2'b01; rob_entry0 = mk(1, 5'(i + 1), 32'(i * 4)); tick();
    end
    check("full_rdy", rob_rdy, 2'b00);
    wb0_val = 1; wb0_tag = 0; wb0_result = 32'h55; tick();
    check("full_commit_rdy_still0", rob_rdy, 2'b00);
    tick();
    check("after_commit_rdy", rob_rdy, 2'b01);

    // Bubble at tail=4.
    flush = 1; tick();
    for (int i = 0; i < 4; i++) begin
      rob_we = 2'b01; rob_entry0 = mk(1, 5'(10 + i), 32'(i)); tick();
    end
    rob_we = 2'b10; rob_entry0 = mk(1, 7, 32'h40); rob_entry1 = mk(1, 9, 32'h44); tick();
    check("bubble_tag0", rob_tag0, 6);
    wb0_val = 1; wb0_tag = 0; wb0_result = 1; wb1_val = 1; wb1_tag = 1; wb1_result = 2; tick();
    wb0_val = 1; wb0_tag = 2; wb0_result = 3; wb1_val = 1; wb1_tag = 3; wb1_result = 4; tick();
    wb0_val = 1; wb0_tag = 5; wb0_result = 6; tick();
    repeat (4) tick();

    // Out-of-order writeback.
    flush = 1; tick();
    rob_we = 2'b11; rob_entry0 = mk(1, 1, 0); rob_entry1 = mk(1, 2, 4); tick();
    rob_we = 2'b01; rob_entry0 = mk(1, 3, 8); tick();
    wb0_val = 1; wb0_tag = 2; wb0_result = 32'h22; tick();
    check("ooo_wait2", commit_0_write_port.we, 0);
    wb0_val = 1; wb0_tag = 1; wb0_result = 32'h11; tick();
    check("ooo_wait1", commit_0_write_port.we, 0);
    wb0_val = 1; wb0_tag = 0; wb0_result = 32'h10; tick();
    check("ooo_c0_tag0", commit_0_write_port.tag, 0);
    check("ooo_c1_we", commit_1_write_port.we, 1);
    check("ooo_c1_tag1", commit_1_write_port.tag, 1);
    tick();
    check("ooo_c0_tag2", commit_0_write_port.tag, 2);
    check("ooo_c1_idle", commit_1_write_port.we, 0);
    tick();

    // Exception at head=3.
    flush = 1; tick();
    rob_we = 2'b11; rob_entry0 = mk(1, 1, 0); rob_entry1 = mk(1, 2, 4); tick();
    rob_we = 2'b01; rob_entry0 = mk(1, 3, 8); tick();
    wb0_val = 1; wb0_tag = 0; wb0_result = 5; wb1_val = 1; wb1_tag = 1; wb1_result = 6; tick();
    wb0_val = 1; wb0_tag = 2; wb0_result = 7; tick();
    tick();
    rob_we = 2'b01; rob_entry0 = mk(1, 4, 32'h100); tick();
    wb0_val = 1; wb0_tag = 3; wb0_result = 8; wb0_exc = 1; tick();
    check("exc_flush_hi", exc_flush, 1);
    check("exc_pc_val", exc_pc, 32'h100);
    check("exc_no_commit", commit_0_write_port.we, 0);
    tick();
    check("exc_flush_lo", exc_flush, 0);
    check("exc_tag0", rob_tag0, 0);
    check("exc_tag1", rob_tag1, 1);
    check("exc_rdy", rob_rdy, 2'b10);

    // Continuous 2-wide allocate/commit past the wrap point.
    flush = 1; tick();
    for (int c = 0; c < 100; c++) begin
      if (D - q.size() >= 2) begin
        rob_we = 2'b11;
        rob_entry0 = mk(1, 5'($urandom_range(1, 31)), $urandom);
        rob_entry1 = mk(1, 5'($urandom_range(1, 31)), $urandom);
      end
      pick_wb(1'b1, 0);
      tick();
    end

    // Random traffic with occasional exceptions and flushes.
    for (int c = 0; c < 3000; c++) rand_cycle(3, 1);

    // Asynchronous reset in the middle of activity.
    for (int c = 0; c < 20; c++) rand_cycle(0, 0);
    #2 rst = 1'b0;
    #1;
    check("areset_rdy", rob_rdy, 2'b10);
    check("areset_tag0", rob_tag0, 0);
    check("areset_tag1", rob_tag1, 1);
    check("areset_c0_we", commit_0_write_port.we, 0);
    check("areset_exc_flush", exc_flush, 0);
    q.delete();
    tail_m = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) rand_cycle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
